// File: rtl/uart_baud_pkg.sv
// rtl/uart_baud_pkg.sv - increment arithmetic shared by the fractional baud generator
// Increments are round(baud * res * 2^accW / clkRate) at the default 50 MHz / x16 / 24-bit setup.
package uart_baud_pkg;

  localparam int DEF_CLK_RATE  = 50_000_000;
  localparam int DEF_RES       = 16;
  localparam int DEF_ACC_W     = 24;

  // Round to nearest; the 64-bit intermediate holds baud*res*2^accW for any realistic rate.
  function automatic longint unsigned calcIncr(
    input longint unsigned clkRate,
    input longint unsigned baud,
    input longint unsigned res,
    input longint unsigned accW
  );
    longint unsigned num;
    num = (baud * res) << accW;
    return (num + (clkRate >> 1)) / clkRate;
  endfunction

  localparam logic [DEF_ACC_W-1:0] INCR_9600   = DEF_ACC_W'(calcIncr(DEF_CLK_RATE, 9600,   DEF_RES, DEF_ACC_W));
  localparam logic [DEF_ACC_W-1:0] INCR_19200  = DEF_ACC_W'(calcIncr(DEF_CLK_RATE, 19200,  DEF_RES, DEF_ACC_W));
  localparam logic [DEF_ACC_W-1:0] INCR_57600  = DEF_ACC_W'(calcIncr(DEF_CLK_RATE, 57600,  DEF_RES, DEF_ACC_W));
  localparam logic [DEF_ACC_W-1:0] INCR_115200 = DEF_ACC_W'(calcIncr(DEF_CLK_RATE, 115200, DEF_RES, DEF_ACC_W));
  localparam logic [DEF_ACC_W-1:0] INCR_230400 = DEF_ACC_W'(calcIncr(DEF_CLK_RATE, 230400, DEF_RES, DEF_ACC_W));
  localparam logic [DEF_ACC_W-1:0] INCR_921600 = DEF_ACC_W'(calcIncr(DEF_CLK_RATE, 921600, DEF_RES, DEF_ACC_W));

endpackage

// File: rtl/uart_phase_acc.sv
// rtl/uart_phase_acc.sv - phase accumulator with loadable increment and carry out
// carry reflects the add that the next enabled edge will commit.
module uart_phase_acc #(
  parameter int ACC_W = 24,
  parameter logic [ACC_W-1:0] RESET_INCR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             load,
  input  logic [ACC_W-1:0] loadIncr,
  output logic             carry
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] incrReg;
  logic [ACC_W:0]   sum;

  assign sum   = {1'b0, acc} + {1'b0, incrReg};
  assign carry = sum[ACC_W];

  // Residue is kept on wrap so the long-term rate carries no drift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum[ACC_W-1:0];
    end
  end

  // A load only changes the rate; the add in the load cycle still uses the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      incrReg <= RESET_INCR;
    end else if (load) begin
      incrReg <= loadIncr;
    end
  end

endmodule

// File: rtl/uart_frac_baud_gen.sv
// rtl/uart_frac_baud_gen.sv - fractional-N oversample, mid-bit and bit tick generator
// One instance per UART channel; restart realigns phase on RX start-bit detect.
module uart_frac_baud_gen
  import uart_baud_pkg::*;
#(
  parameter int CLK_RATE   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int RESOLUTION = 16,
  parameter int ACC_W      = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic             cfgLoad,
  input  logic [ACC_W-1:0] cfgIncr,
  output logic             sampleTick,
  output logic             midTick,
  output logic             bitTick
);

  localparam int SUB_W = $clog2(RESOLUTION);
  localparam logic [ACC_W-1:0] DEFAULT_INCR =
    ACC_W'(calcIncr(CLK_RATE, BAUD_RATE, RESOLUTION, ACC_W));
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(RESOLUTION - 1);
  localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(RESOLUTION / 2 - 1);

  logic             carry;
  logic [SUB_W-1:0] subCnt;

  uart_phase_acc #(
    .ACC_W      (ACC_W),
    .RESET_INCR (DEFAULT_INCR)
  ) u_phase_acc (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clear    (restart),
    .load     (cfgLoad),
    .loadIncr (cfgIncr),
    .carry    (carry)
  );

  // restart outranks en; ticks are registered from the carry of the committed add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      subCnt     <= '0;
      sampleTick <= 1'b0;
      midTick    <= 1'b0;
      bitTick    <= 1'b0;
    end else if (restart) begin
      subCnt     <= '0;
      sampleTick <= 1'b0;
      midTick    <= 1'b0;
      bitTick    <= 1'b0;
    end else if (en) begin
      sampleTick <= carry;
      bitTick    <= carry & (subCnt == SUB_LAST);
      midTick    <= carry & (subCnt == SUB_MID);
      if (carry) begin
        subCnt <= (subCnt == SUB_LAST) ? '0 : subCnt + 1'b1;
      end
    end else begin
      sampleTick <= 1'b0;
      midTick    <= 1'b0;
      bitTick    <= 1'b0;
    end
  end

endmodule
